ft60x_fifo_bfm: RTL

FT60X_FIFO_BFM -- requirements
Module: ft60x_fifo_bfm

---
 rtl/ft60x_fifo_bfm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ft60x_fifo_bfm.sv
// Bus-functional model of an FT60x 245-style synchronous FIFO bridge: per-channel RX/TX FIFOs, bus read FSM and host-side preload/capture.
// Optional statistics outputs are enabled with FT60X_BFM_STATS_EN.
`timescale 1ns/1ps
module ft60x_fifo_bfm #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 512,
    parameter int TXE_MARGIN = 0,
    parameter int TURNAROUND = 1,
    localparam int BW = DATA_WIDTH / 8,
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] data,
    inout  wire  [BW-1:0]         be,
    input  logic                  oe_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    output logic [NUM_CH-1:0]     rxf_n,
    output logic [NUM_CH-1:0]     txe_n,
    input  logic [CW-1:0]         rd_ch_sel,
    input  logic [CW-1:0]         wr_ch_sel,
    input  logic [NUM_CH-1:0]     flag_stall,
    input  logic                  rx_host_wr_en,
    input  logic [CW-1:0]         rx_host_wr_ch,
    input  logic [DATA_WIDTH-1:0] rx_host_wr_data,
    input  logic [BW-1:0]         rx_host_wr_be,
    output logic                  rx_host_wr_ready,
    input  logic                  tx_host_rd_en,
    input  logic [CW-1:0]         tx_host_rd_ch,
    output logic                  tx_host_rd_valid,
    output logic [DATA_WIDTH-1:0] tx_host_rd_data,
    output logic [BW-1:0]         tx_host_rd_be,
    output logic                  proto_err
`ifdef FT60X_BFM_STATS_EN
    ,
    output logic [31:0]           rd_word_cnt,
    output logic [31:0]           wr_word_cnt,
    output logic [31:0]           drop_cnt
`endif
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam int WW   = DATA_WIDTH + BW;
    localparam logic [CNTW-1:0] FULL_LEVEL = CNTW'(FIFO_DEPTH);
    localparam logic [CNTW-1:0] TXE_LEVEL  = CNTW'(FIFO_DEPTH - TXE_MARGIN);

    typedef enum logic [1:0] {IDLE, TURN, DATA} rd_state_t;

    rd_state_t   state_reg, state_next;
    logic [1:0]  turn_cnt_reg, turn_cnt_next;

    logic rd_sel_ok, wr_sel_ok, rx_host_sel_ok, tx_host_sel_ok;
    logic rd_pop_ok, wr_ok, err_event;
    logic [NUM_CH-1:0] rx_empty, rx_full, tx_level_hit;
    logic [NUM_CH-1:0] rx_push, rx_pop, tx_push, tx_pop;
    logic [WW-1:0]     rx_head [NUM_CH];
    logic [WW-1:0]     tx_q    [NUM_CH];
    logic [WW-1:0]     bus_word;
    logic              drive_en;
    logic              tx_valid_reg;
    logic [CW-1:0]     tx_sel_reg;
    logic              proto_err_reg;

    assign rd_sel_ok      = {1'b0, rd_ch_sel}     < (CW+1)'(NUM_CH);
    assign wr_sel_ok      = {1'b0, wr_ch_sel}     < (CW+1)'(NUM_CH);
    assign rx_host_sel_ok = {1'b0, rx_host_wr_ch} < (CW+1)'(NUM_CH);
    assign tx_host_sel_ok = {1'b0, tx_host_rd_ch} < (CW+1)'(NUM_CH);

    assign rd_pop_ok = (state_reg == DATA) && !oe_n && !rd_n && rd_sel_ok;
    assign wr_ok     = !wr_n && oe_n && wr_sel_ok;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : gen_ch
            logic [WW-1:0]   rx_mem [FIFO_DEPTH];
            logic [WW-1:0]   tx_mem [FIFO_DEPTH];
            logic [AW-1:0]   rx_wr_ptr_reg, rx_rd_ptr_reg, tx_wr_ptr_reg, tx_rd_ptr_reg;
            logic [CNTW-1:0] rx_count_reg, tx_count_reg;
            logic [WW-1:0]   tx_q_reg;

            assign rx_push[gi] = rx_host_wr_en && rx_host_sel_ok && (rx_host_wr_ch == CW'(gi)) && !rx_full[gi];
            assign rx_pop[gi]  = rd_pop_ok && (rd_ch_sel == CW'(gi)) && !rxf_n[gi];
            assign tx_push[gi] = wr_ok && (wr_ch_sel == CW'(gi)) && !txe_n[gi];
            assign tx_pop[gi]  = tx_host_rd_en && tx_host_sel_ok && (tx_host_rd_ch == CW'(gi))
                                 && (tx_count_reg != '0);

            assign rx_empty[gi]     = (rx_count_reg == '0);
            assign rx_full[gi]      = (rx_count_reg == FULL_LEVEL);
            assign tx_level_hit[gi] = (tx_count_reg >= TXE_LEVEL);
            assign rxf_n[gi]        = rx_empty[gi] | flag_stall[gi];
            assign txe_n[gi]        = tx_level_hit[gi] | flag_stall[gi];
            assign rx_head[gi]      = rx_mem[rx_rd_ptr_reg];
            assign tx_q[gi]         = tx_q_reg;

            // Storage carries no reset; the TX side uses a registered read port.
            always_ff @(posedge clk) begin
                if (rx_push[gi])
                    rx_mem[rx_wr_ptr_reg] <= {rx_host_wr_be, rx_host_wr_data};
                if (tx_push[gi])
                    tx_mem[tx_wr_ptr_reg] <= {be, data};
                if (tx_pop[gi])
                    tx_q_reg <= tx_mem[tx_rd_ptr_reg];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rx_wr_ptr_reg <= '0;
                    rx_rd_ptr_reg <= '0;
                    rx_count_reg  <= '0;
                    tx_wr_ptr_reg <= '0;
                    tx_rd_ptr_reg <= '0;
                    tx_count_reg  <= '0;
                end else begin
                    if (rx_push[gi]) rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
                    if (rx_pop[gi])  rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
                    if (tx_push[gi]) tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
                    if (tx_pop[gi])  tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
                    case ({rx_push[gi], rx_pop[gi]})
                        2'b10:   rx_count_reg <= rx_count_reg + 1'b1;
                        2'b01:   rx_count_reg <= rx_count_reg - 1'b1;
                        default: rx_count_reg <= rx_count_reg;
                    endcase
                    case ({tx_push[gi], tx_pop[gi]})
                        2'b10:   tx_count_reg <= tx_count_reg + 1'b1;
                        2'b01:   tx_count_reg <= tx_count_reg - 1'b1;
                        default: tx_count_reg <= tx_count_reg;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            turn_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            turn_cnt_reg <= turn_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        turn_cnt_next = turn_cnt_reg;
        if (oe_n) begin
            state_next    = IDLE;
            turn_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    turn_cnt_next = '0;
                    state_next    = (TURNAROUND == 0) ? DATA : TURN;
                end
                TURN: begin
                    if (turn_cnt_reg == 2'(TURNAROUND - 1))
                        state_next = DATA;
                    else
                        turn_cnt_next = turn_cnt_reg + 2'd1;
                end
                DATA:    state_next = DATA;
                default: state_next = IDLE;
            endcase
        end
    end

    // An empty (or invalid) read channel still drives the bus, with zeros.
    always_comb begin
        bus_word = '0;
        if (rd_sel_ok && !rx_empty[rd_ch_sel])
            bus_word = rx_head[rd_ch_sel];
    end

    assign drive_en = (state_reg == DATA) && !oe_n;
    assign data     = drive_en ? bus_word[DATA_WIDTH-1:0] : 'z;
    assign be       = drive_en ? bus_word[WW-1 -: BW]     : 'z;

    assign rx_host_wr_ready = rx_host_sel_ok && !rx_full[rx_host_wr_ch];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid_reg <= 1'b0;
            tx_sel_reg   <= '0;
        end else begin
            tx_valid_reg <= |tx_pop;
            if (|tx_pop)
                tx_sel_reg <= tx_host_rd_ch;
        end
    end

    assign tx_host_rd_valid = tx_valid_reg;
    assign tx_host_rd_data  = tx_q[tx_sel_reg][DATA_WIDTH-1:0];
    assign tx_host_rd_be    = tx_q[tx_sel_reg][WW-1 -: BW];

    assign err_event = (!wr_n && !oe_n)
                    || (!wr_n && (!wr_sel_ok || txe_n[wr_ch_sel]))
                    || (!rd_n && (state_reg != DATA || !rd_sel_ok))
                    || (rx_host_wr_en && !rx_host_sel_ok)
                    || (tx_host_rd_en && !tx_host_sel_ok);

    always_ff @(posedge clk) begin
        if (rst)
            proto_err_reg <= 1'b0;
        else if (err_event)
            proto_err_reg <= 1'b1;
    end

    assign proto_err = proto_err_reg;

`ifdef FT60X_BFM_STATS_EN
    logic [31:0] rd_word_cnt_reg, wr_word_cnt_reg, drop_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_cnt_reg <= '0;
            wr_word_cnt_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            if (|rx_pop)              rd_word_cnt_reg <= rd_word_cnt_reg + 32'd1;
            if (|tx_push)             wr_word_cnt_reg <= wr_word_cnt_reg + 32'd1;
            if (!wr_n && !(|tx_push)) drop_cnt_reg    <= drop_cnt_reg + 32'd1;
        end
    end

    assign rd_word_cnt = rd_word_cnt_reg;
    assign wr_word_cnt = wr_word_cnt_reg;
    assign drop_cnt    = drop_cnt_reg;
`endif

endmodule
